fifo_vr_buffer: RTL and testbench

- Synchronous FIFO with valid/ready handshakes on both sides; holds DEPTH words of WIDTH bits.
- Sits between a producer stage and a consumer stage so neither stalls the other cycle-by-cycle.
- Written for synthesis onto the team's CMOS cell library (DFF, DFFSR, NAND, NOR, NOT, BUF), then run through qflow static timing analysis as the next timing-design target.

---
 rtl/fifo_vr_buffer.sv | 119 +++++++++++
 tb/tb_fifo_vr_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_vr_buffer.sv
// fifo_vr_buffer
// ---------------------------------------------------------------------------
// Synchronous first-word-fall-through FIFO with valid/ready handshakes on both
// sides. It decouples a producer stage from a consumer stage so that a
// one-cycle stall on either side does not stall the other.
//
// Parameters
//   WIDTH  data word width in bits (>= 1)
//   DEPTH  number of storage entries (power of two, >= 2)
//   AW     pointer index width, derived as log2(DEPTH)
//
// Ports
//   C          clock, rising edge active
//   R          asynchronous active-low reset; clears pointers and storage
//   in_data    write data
//   in_valid   producer offers a word
//   in_ready   FIFO can accept a word (not full)
//   out_data   head-of-queue word (0 when empty after reset)
//   out_valid  out_data holds a valid word (not empty)
//   out_ready  consumer takes out_data
//   level      occupancy 0..DEPTH (only when FIFO_LEVEL_EN is defined)
//
// Optional feature macro: FIFO_LEVEL_EN adds the level output.
// ---------------------------------------------------------------------------
module fifo_vr_buffer #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FIFO_LEVEL_EN
    ,
    output logic [AW:0]      level
`endif
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits coincide.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] mem_reg [DEPTH];

    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign rd_idx = rd_ptr_reg[AW-1:0];

    // Flags come from registered pointers only, so neither handshake input
    // has a combinational path to the opposite-side flag.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;

    // Qualifying with the flags makes push-while-full a pop only and
    // pop-while-empty a push only.
    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    // Per-entry write enable decode.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_idx == AW'(gi));
        end
    endgenerate

    // Storage is flop based: it must clear on reset and be readable in the
    // same cycle (first-word fall-through), which rules out a synchronous-read RAM.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    assign out_data = mem_reg[rd_idx];

`ifdef FIFO_LEVEL_EN
    // Modulo-2^(AW+1) difference is the occupancy even across pointer wrap.
    assign level = wr_ptr_reg - rd_ptr_reg;
`endif

endmodule

// File: tb/tb_fifo_vr_buffer.sv
// Testbench for fifo_vr_buffer (WIDTH=8, DEPTH=4).
// Data ordering is checked by a scoreboard: the driver pushes each word into
// exp_q when it sees the word will be accepted, and an independent monitor
// pops and compares on every handshake. Flag/level checks are directed.
module tb_fifo_vr_buffer;

    logic       C;
    logic       R;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef FIFO_LEVEL_EN
    logic [2:0] level;
`endif

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int stalls = 0;
    logic [7:0] exp_q [$];

    fifo_vr_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .C         (C),
        .R         (R),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FIFO_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_level(input string name, input int exp);
`ifdef FIFO_LEVEL_EN
        check(name, 32'(level), 32'(exp));
`endif
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next rise.
    always @(negedge C) begin
        if (R && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %0h expected %0h", out_data, e);
                end else begin
                    $display("pop %0d data=%0h", pops, out_data);
                end
            end
            pops++;
        end
    end

    task automatic step();
        @(posedge C);
        #1;
    endtask

    // Offer one word; hold it until accepted (bounded).
    task automatic send(input logic [7:0] d);
        bit done;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge C);
            if (in_ready) begin
                exp_q.push_back(d);
                done = 1;
            end else begin
                stalls++;
            end
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got not_accepted expected accepted data=%0h", d);
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            step();
            if (exp_q.size() == 0 && !out_valid) done = 1;
        end
        check("drain_done", 32'(done), 32'd1);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check_level("drain_level", 0);
        out_ready = 1'b0;
    endtask

    initial begin
        R = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check_level("rst_level", 0);
        @(negedge C);
        @(negedge C);
        R = 1'b1;
        step();

        // Fill to full with consumer stalled.
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_data", 32'(out_data), 32'h01);
        check_level("full_level", 4);
        // Fifth word held for three cycles while full: must not be taken.
        in_valid = 1'b1;
        in_data = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(negedge C);
            check("held_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        check_level("held_level", 4);
        // Full with push and pop: pop only.
        out_ready = 1'b1;
        @(negedge C);
        check("fullpp_in_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        check("fullpp_in_ready_after", 32'(in_ready), 32'd1);
        check("fullpp_out_data", 32'(out_data), 32'h02);
        check_level("fullpp_level", 3);
        send(8'h05);
        check_level("refill_level", 4);
        drain();

        // Empty with push and pop together: push only.
        out_ready = 1'b1;
        send(8'h3C);
        check("empty_out_valid", 32'(out_valid), 32'd1);
        check("empty_out_data", 32'(out_data), 32'h3C);
        check("empty_nopop", 32'(pops), 32'd5);
        drain();

        // Streaming across pointer wrap: 256 back-to-back words.
        pops = 0;
        stalls = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
        end
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_pops_before_last", 32'(pops), 32'd255);
        drain();
        check("stream_pops", 32'(pops), 32'd256);

        // Reset mid-run with three words stored.
        send(8'h11);
        send(8'h22);
        send(8'h33);
        check_level("prerst_level", 3);
        #3;
        R = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check_level("midrst_level", 0);
        exp_q.delete();
        // An edge while still in reset must not push.
        in_valid = 1'b1;
        in_data = 8'hEE;
        out_ready = 1'b1;
        step();
        check("inrst_no_push", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge C);
        R = 1'b1;
        step();
        send(8'hA5);
        check("postrst_out_data", 32'(out_data), 32'hA5);
        check_level("postrst_level", 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
